// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - state encoding and default constants for prog_loader (PROG_LOADER_CSUM_EN adds CSUM)
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int WORD_W_DEF = 12;

  // Bits of the HI byte that must be zero; only the low nibble carries instr[11:8].
  localparam logic [7:0] HI_MASK = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
`ifdef PROG_LOADER_CSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial byte-stream program loader; PROG_LOADER_CSUM_EN enables trailing checksum
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [WORD_W-1:0] pmem_wdata,
  output logic              pmem_we,
  output logic              load_active,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [3:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              accept;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  // Ready in every state that is waiting for a stream byte.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_COUNT, S_HI, S_LO: in_ready = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM:              in_ready = 1'b1;
`endif
      default:             in_ready = 1'b0;
    endcase
  end

  assign accept      = in_valid & in_ready;
  // The final write lands after the FSM has left LO, so the pending strobe keeps the core held.
  assign load_active = in_ready | we_q;
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERROR);
  assign pmem_addr   = addr_q;
  assign pmem_wdata  = wdata_q;
  assign pmem_we     = we_q;

  // Next-state, word assembly, address advance and running sum.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    sum_d   = sum_q;
    if (accept && state_q != S_CSUM) begin
      sum_d = sum_q + in_data;
    end
`endif
    // Address moves on in the cycle that carries the strobe.
    if (we_q) begin
      addr_d = addr_q + ADDR_ONE;
    end
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_COUNT;
          addr_d  = '0;
`ifdef PROG_LOADER_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_COUNT: begin
        if (accept) begin
          count_d = ADDR_W'(in_data);
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          if ((in_data & HI_MASK) != 8'h00) begin
            state_d = S_ERROR;
          end else begin
            hi_d    = in_data[3:0];
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = WORD_W'({hi_q, in_data});
          // Count 0 wraps to all-ones here, giving 2^ADDR_W words.
          if (addr_q == count_q - ADDR_ONE) begin
`ifdef PROG_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_HI;
          end
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
`ifdef PROG_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter ADDR_W SHALL default to 8 and set the program-memory address width.
REQ-003 Parameter WORD_W SHALL default to 12 and set the instruction width.
REQ-004 Port clk SHALL be a 1-bit input and the single rising-edge clock.
REQ-005 Port rst SHALL be a 1-bit input and the asynchronous active-low reset.
REQ-006 Port start SHALL be a 1-bit input; a 1-cycle pulse begins a load session.
REQ-007 Port in_data SHALL be an 8-bit input carrying the serial byte stream.
REQ-008 Port in_valid SHALL be a 1-bit input; the source holds in_data valid.
REQ-009 Port in_ready SHALL be a 1-bit output; the loader accepts the byte.
REQ-010 Port pmem_addr SHALL be an ADDR_W-bit output giving the program-memory write address.
REQ-011 Port pmem_wdata SHALL be a WORD_W-bit output giving the instruction word written.
REQ-012 Port pmem_we SHALL be a 1-bit output acting as the 1-cycle program-memory write strobe.
REQ-013 Port load_active SHALL be a 1-bit output; it holds the core in its LOAD state.
REQ-014 Port done SHALL be a 1-bit output indicating a session completed OK.
REQ-015 Port err SHALL be a 1-bit output indicating a session aborted on a format or checksum fault.

Function
REQ-016 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-017 The states SHALL be IDLE, COUNT, HI, LO, CSUM, DONE and ERROR.
REQ-018 IDLE, DONE and ERROR SHALL go to COUNT on start and clear done, err, the address counter and the sum.
REQ-019 start asserted in COUNT, HI, LO or CSUM SHALL be ignored.
REQ-020 COUNT SHALL latch the accepted byte as the word count N, with 0 meaning 2^ADDR_W words, then go to HI.
REQ-021 HI SHALL take instr[11:8] from in_data[3:0]; in_data[7:4] != 0 SHALL go to ERROR.
REQ-022 LO SHALL take instr[7:0]; on acceptance, the next cycle SHALL present pmem_we=1 with the assembled word and the current address.
REQ-023 The address SHALL increment after each write; after word N the FSM SHALL go to CSUM (macro on) or DONE, otherwise back to HI.
REQ-024 The address SHALL wrap from 2^ADDR_W-1 to 0 only when N=0, i.e. exactly at session end.
REQ-025 in_ready SHALL be 1 in COUNT, HI, LO and CSUM, and 0 in IDLE, DONE and ERROR.
REQ-026 pmem_we SHALL never be high in two consecutive cycles, and the loader SHALL sustain one byte per cycle.
REQ-027 load_active SHALL be 1 in COUNT, HI, LO and CSUM, and in the cycle carrying the final pmem_we.
REQ-028 done and err SHALL be sticky levels, mutually exclusive, held until the next start.
REQ-029 A stalled source (in_valid low) SHALL freeze the FSM with no timeout.

Reset
REQ-030 Reset SHALL force IDLE, with pmem_we, in_ready, load_active, done and err all 0, and pmem_addr, pmem_wdata, N and the sum all 0.
REQ-031 Reset mid-session SHALL abort immediately; the partially written memory SHALL be left as is, with no further writes.

Configuration
REQ-032 Macro PROG_LOADER_CSUM_EN SHALL select checksum handling.
REQ-033 With the macro defined, CSUM SHALL compare one trailing byte to the mod-256 sum of all bytes from N through the last LO byte; a match SHALL go to DONE and a mismatch to ERROR.
REQ-034 Without the macro, the CSUM state and the sum register SHALL be absent, and the last write SHALL go directly to DONE.

Structure
REQ-035 Package prog_loader_pkg SHALL hold the state encoding, the default ADDR_W/WORD_W constants and the HI-nibble mask.
REQ-036 The block SHALL be a single module with no sub-module; the byte-pair assembly is inline.

Verification
REQ-037 Macro off: start, then bytes 02,01,23,0A,BC SHALL produce writes addr0=0x123 and addr1=0xABC, then done=1 and load_active=0.
REQ-038 In_valid throttled 50% at random: the writes SHALL be identical to the back-to-back case, with each pmem_we exactly 1 cycle wide.
REQ-039 Bytes 01,F1,00 SHALL cause err=1 after the HI byte, no pmem_we and in_ready=0.
REQ-040 N=00 with 256 words SHALL write addresses 0..255 in order, with the last write at addr 0xFF, then done.
REQ-041 Macro on: bytes 01,01,23,25 SHALL produce done; a trailing byte of 26 SHALL produce err, with the word still written.
REQ-042 rst low asserted after the first word, with start pulses during the session, SHALL leave outputs at reset values, IDLE state, and no further writes.
